// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array and its feeders.
package systolic_pkg;

  localparam int unsigned DATAWIDTH_DEF = 8;
  localparam int unsigned N_DEF         = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth {data, valid} register chain for one activation lane.
// The output is forced to zero whenever the emerging slot is invalid.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d,
  input  logic         v,
  output logic [W-1:0] q,
  output logic         qv
);

  logic [W-1:0]     dat [DEPTH];
  logic [DEPTH-1:0] vld;

  // Shift the chain every cycle; invalid slots carry zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
      vld <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
      vld <= '0;
    end else begin
      dat[0] <= v ? d : '0;
      vld[0] <= v;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        dat[i] <= dat[i-1];
        vld[i] <= vld[i-1];
      end
    end
  end

  assign qv = vld[DEPTH-1];
  assign q  = vld[DEPTH-1] ? dat[DEPTH-1] : '0;

endmodule

// File: rtl/systolic_act_skewer.sv
// Activation feeder: accepts one N-lane vector per cycle and emits it
// diagonally skewed (lane i delayed i extra cycles), then drains and
// pulses done after the last vector of a tile.
module systolic_act_skewer
  import systolic_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned N         = N_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N*DATAWIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic [N*DATAWIDTH-1:0] a_out,
  output logic [N-1:0]           a_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned      CW       = $clog2(N);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(N - 2);

  skew_state_e   state;
  logic [CW-1:0] cnt;
  logic          accept;

  // Ready is held low during reset even though state already reads IDLE.
  assign s_ready = rst_n && (state != DRAIN);
  assign accept  = s_valid && s_ready && !clr;
  assign busy    = (state != IDLE);

  // Tile FSM: stream until the last vector, then count out the skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (s_last) begin
              state <= DRAIN;
              cnt   <= CNT_LOAD;
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH (i + 1),
      .W     (DATAWIDTH)
    ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .d     (accept ? s_data[i*DATAWIDTH +: DATAWIDTH] : '0),
      .v     (accept),
      .q     (a_out[i*DATAWIDTH +: DATAWIDTH]),
      .qv    (a_valid[i])
    );
  end

endmodule

// File: tb/tb_systolic_act_skewer.sv
// Self-checking bench for systolic_act_skewer (N=4, DATAWIDTH=8).
// Reference model: a timestamped list of accepted vectors; a lane's output
// after edge e is the vector accepted on edge e-lane.
module tb_systolic_act_skewer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [N*DW-1:0] s_data = '0;
  logic            s_last = 1'b0;
  logic [N*DW-1:0] a_out;
  logic [N-1:0]    a_valid;
  logic            busy;
  logic            done;

  systolic_act_skewer #(.DATAWIDTH(DW), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .a_out   (a_out),
    .a_valid (a_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              ed;
    logic [N*DW-1:0] data;
    logic            last;
  } acc_t;

  acc_t acc_q[$];
  int   edge_cnt  = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic in_tile   = 1'b0;

  logic [N*DW-1:0] exp_a     = '0;
  logic [N-1:0]    exp_v     = '0;
  logic            exp_done  = 1'b0;
  logic            exp_ready = 1'b0;
  logic            exp_busy  = 1'b0;

  task automatic model_update(input logic acc, input logic was_clr);
    exp_a     = '0;
    exp_v     = '0;
    exp_done  = 1'b0;
    exp_ready = 1'b1;
    foreach (acc_q[j]) begin
      int age;
      age = edge_cnt - acc_q[j].ed;
      if (age >= 0 && age < N) begin
        exp_v[age] = 1'b1;
        exp_a[age*DW +: DW] = acc_q[j].data[age*DW +: DW];
      end
      if (acc_q[j].last && age == N - 1) exp_done = 1'b1;
      if (acc_q[j].last && age <= N - 2) exp_ready = 1'b0;
    end
    if (was_clr) in_tile = 1'b0;
    else if (acc) in_tile = 1'b1;
    if (exp_done) in_tile = 1'b0;
    exp_busy = in_tile;
    while (acc_q.size() > 0 && edge_cnt - acc_q[0].ed >= N) void'(acc_q.pop_front());
  endtask

  task automatic model_reset();
    acc_q.delete();
    in_tile   = 1'b0;
    exp_a     = '0;
    exp_v     = '0;
    exp_done  = 1'b0;
    exp_busy  = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic tick();
    logic acc, c;
    acc = s_valid && exp_ready && !clr;
    c   = clr;
    @(posedge clk);
    edge_cnt++;
    if (c) acc_q.delete();
    else if (acc) acc_q.push_back('{edge_cnt, s_data, s_last});
    model_update(acc, c);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({a_out, a_valid, done, busy, s_ready} !== '0)
      $display("FAIL reset_hold got=%h exp=0", {a_out, a_valid, done, busy, s_ready});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if ({s_ready, busy} !== 2'b10)
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", s_ready, busy);
    else pass_cnt++;
    // stream two vectors, then reset asynchronously mid-flight
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_last = 1'b0; s_data = $urandom;
      tick();
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL reset_stream got=%h exp=%h", {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({a_out, a_valid, done, busy, s_ready} !== '0)
      $display("FAIL reset_midstream got=%h exp=0", {a_out, a_valid, done, busy, s_ready});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < N + 1; k++) begin
      tick();
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL reset_after got=%h exp=%h", {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int rdy_low, done_cnt;
    rdy_low = 0; done_cnt = 0;
    s_valid = 1'b1; s_last = 1'b1; s_data = 32'h04030201;
    tick();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    total_cnt++;
    if (a_valid[0] !== 1'b1 || a_out[7:0] !== 8'h01)
      $display("FAIL single_lane0 got v=%b d=%h exp v=1 d=01", a_valid[0], a_out[7:0]);
    else pass_cnt++;
    for (int k = 0; k < N + 3; k++) begin
      if (!s_ready) rdy_low++;
      if (done) done_cnt++;
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL single_cycle got=%h exp=%h", {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (rdy_low !== N - 1) $display("FAIL single_ready_low got=%0d exp=%0d", rdy_low, N - 1);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL single_done_count got=%0d exp=1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    int lane_cnt[N];
    foreach (lane_cnt[i]) lane_cnt[i] = 0;
    for (int k = 0; k < 5 + N + 2; k++) begin
      s_valid = (k < 5);
      s_last  = (k == 4);
      s_data  = (k < 5) ? $urandom : '0;
      tick();
      for (int i = 0; i < N; i++) if (a_valid[i]) lane_cnt[i]++;
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL stream_cycle k=%0d got=%h exp=%h", k, {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (lane_cnt[i] !== 5) $display("FAIL stream_lane_count lane=%0d got=%0d exp=5", i, lane_cnt[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gap();
    logic [3:0] vpat;
    logic [3:0] lpat;
    vpat = 4'b1011;  // v0, v1, gap, v2
    lpat = 4'b1000;
    for (int k = 0; k < 4 + N + 2; k++) begin
      s_valid = (k < 4) ? vpat[k] : 1'b0;
      s_last  = (k < 4) ? lpat[k] : 1'b0;
      s_data  = $urandom;
      tick();
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL gap_cycle k=%0d got=%h exp=%h", k, {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_clr_drain();
    int done_cnt;
    done_cnt = 0;
    s_valid = 1'b1; s_last = 1'b1; s_data = $urandom;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total_cnt++;
    if ({a_valid, s_ready, busy, done} !== {{N{1'b0}}, 3'b100})
      $display("FAIL clr_drain got v=%b ready=%b busy=%b done=%b exp v=0 ready=1 busy=0 done=0",
               a_valid, s_ready, busy, done);
    else pass_cnt++;
    for (int k = 0; k < N + 2; k++) begin
      if (done) done_cnt++;
      tick();
    end
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL clr_no_done got=%0d exp=0", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_accept_on_done();
    int   waited;
    logic [N*DW-1:0] v2;
    waited = 0;
    s_valid = 1'b1; s_last = 1'b1; s_data = $urandom;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    while (!exp_done && waited < 2 * N) begin
      tick();
      waited++;
    end
    total_cnt++;
    if (done !== 1'b1 || s_ready !== 1'b1)
      $display("FAIL done_cycle got done=%b ready=%b exp done=1 ready=1 waited=%0d", done, s_ready, waited);
    else pass_cnt++;
    v2 = $urandom;
    s_valid = 1'b1; s_last = 1'b1; s_data = v2;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    total_cnt++;
    if (a_valid[0] !== 1'b1 || a_out[DW-1:0] !== v2[DW-1:0])
      $display("FAIL done_reaccept_lane0 got v=%b d=%h exp v=1 d=%h", a_valid[0], a_out[DW-1:0], v2[DW-1:0]);
    else pass_cnt++;
    for (int k = 0; k < N + 1; k++) begin
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL done_reaccept_cycle got=%h exp=%h", {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_last  = ($urandom_range(0, 4) == 0);
      clr     = ($urandom_range(0, 30) == 0);
      s_data  = $urandom;
      tick();
      total_cnt++;
      if ({a_out, a_valid, done, s_ready, busy} !== {exp_a, exp_v, exp_done, exp_ready, exp_busy})
        $display("FAIL random_cycle k=%0d got=%h exp=%h", k, {a_out, a_valid, done, s_ready, busy},
                 {exp_a, exp_v, exp_done, exp_ready, exp_busy});
      else pass_cnt++;
    end
    s_valid = 1'b0; s_last = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_gap();
    test_clr_drain();
    test_accept_on_done();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
